// File: rtl/rr_receiver_queue.sv
// Multi-source receiver queue: one FIFO per input source, drained through a
// registered output by a work-conserving round-robin arbiter.
module rr_receiver_queue #(
    parameter int WIDTH  = 32,
    parameter int NPORTS = 3,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(NPORTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*WIDTH-1:0]  in_data,
    input  logic [NPORTS-1:0]        in_valid,
    output logic [NPORTS-1:0]        in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PW-1:0]            out_port,
    output logic [NPORTS-1:0]        overflow
);

    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem  [NPORTS][DEPTH];
    logic [PTRW-1:0]   r_wptr [NPORTS];
    logic [PTRW-1:0]   r_rptr [NPORTS];
    logic [PTRW:0]     r_cnt  [NPORTS];
    logic [PW-1:0]     r_last;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic [PW-1:0]     r_out_port;
    logic [NPORTS-1:0] r_overflow;

    logic [NPORTS-1:0] w_push;
    logic [NPORTS-1:0] w_pop;
    logic              w_load;
    logic              w_found;
    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_cand;

    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            in_ready[p] = (r_cnt[p] != (PTRW+1)'(DEPTH));
        end
        w_push = in_valid & in_ready;
    end

    // Scan last+1 .. last+NPORTS so the port just granted is considered last.
    always_comb begin
        w_load  = !r_out_valid || out_ready;
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= NPORTS; i++) begin
            w_cand = PW'((32'(r_last) + i) % NPORTS);
            if (!w_found && r_cnt[w_cand] != '0) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        w_pop = (w_load && w_found) ? (NPORTS'(1) << w_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned p = 0; p < NPORTS; p++) begin
                if (w_push[p]) begin
                    r_mem[p][r_wptr[p]] <= in_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned p = 0; p < NPORTS; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
            end
            r_last      <= PW'(NPORTS - 1);
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_port  <= '0;
            r_overflow  <= '0;
        end else begin
            for (int unsigned p = 0; p < NPORTS; p++) begin
                if (w_push[p]) begin
                    r_wptr[p] <= r_wptr[p] + 1'b1;
                end
                if (w_pop[p]) begin
                    r_rptr[p] <= r_rptr[p] + 1'b1;
                end
                r_cnt[p] <= r_cnt[p] + (PTRW+1)'(w_push[p]) - (PTRW+1)'(w_pop[p]);
            end
            r_overflow <= r_overflow | (in_valid & ~in_ready);
            if (w_load) begin
                if (w_found) begin
                    r_out_data  <= r_mem[w_idx][r_rptr[w_idx]];
                    r_out_port  <= w_idx;
                    r_out_valid <= 1'b1;
                    r_last      <= w_idx;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_port  = r_out_port;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_rr_receiver_queue.sv
// Scoreboard bench for rr_receiver_queue: stimulus queues expected output words,
// a negedge monitor pops and compares every accepted output.
module tb_rr_receiver_queue;

    localparam int WIDTH  = 32;
    localparam int NPORTS = 3;
    localparam int DEPTH  = 4;
    localparam int PW     = 2;

    logic                    clk;
    logic                    reset;
    logic [NPORTS*WIDTH-1:0] in_data;
    logic [NPORTS-1:0]       in_valid;
    logic [NPORTS-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [PW-1:0]           out_port;
    logic [NPORTS-1:0]       overflow;

    typedef struct {
        logic [PW-1:0]    port;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    rr_receiver_queue #(.WIDTH(WIDTH), .NPORTS(NPORTS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_port  (out_port),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int p, input logic [WIDTH-1:0] d);
        in_data[p*WIDTH +: WIDTH] = d;
    endtask

    task automatic expect_word(input int p, input logic [WIDTH-1:0] d);
        exp_t e;
        e.port = PW'(p);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    // Monitor: a word transfers on the next edge when valid & ready at negedge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL sb_unexpected: got port %0d data %0h expected no word", out_port, out_data);
            end else begin
                e = sb.pop_front();
                check("sb_port", 64'(out_port), 64'(e.port));
                check("sb_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // 1: reset with inputs active
        reset     = 1'b1;
        in_valid  = '1;
        in_data   = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        out_ready = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = '0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'b111);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_port",  64'(out_port),  64'd0);
        tick();
        tick();
        check("rst_nothing_stored", 64'(out_valid), 64'd0);

        // 2: single word, latency
        set_word(1, 32'hA5A5_0001);
        in_valid = 3'b010;
        expect_word(1, 32'hA5A5_0001);
        tick();
        in_valid = '0;
        check("single_no_bypass", 64'(out_valid), 64'd0);
        tick();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_port",  64'(out_port),  64'd1);
        check("single_data",  64'(out_data),  64'hA5A5_0001);
        tick();
        check("single_idle", 64'(out_valid), 64'd0);

        // 3: round robin over three loaded ports
        do_reset();
        out_ready = 1'b0;
        in_valid  = 3'b111;
        for (int w = 0; w < 2; w++) begin
            for (int p = 0; p < NPORTS; p++) begin
                set_word(p, 32'h3000_0000 | 32'(p << 8) | 32'(w));
                expect_word(p, 32'h3000_0000 | 32'(p << 8) | 32'(w));
            end
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rr_busy", 64'(out_valid), 64'd1);
            tick();
        end
        check("rr_idle", 64'(out_valid), 64'd0);

        // 4: empty port 1 is skipped
        do_reset();
        out_ready = 1'b0;
        in_valid  = 3'b101;
        for (int w = 0; w < 3; w++) begin
            set_word(0, 32'h4000_0000 | 32'(w));
            set_word(2, 32'h4000_0200 | 32'(w));
            expect_word(0, 32'h4000_0000 | 32'(w));
            expect_word(2, 32'h4000_0200 | 32'(w));
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("skip_busy", 64'(out_valid), 64'd1);
            tick();
        end
        check("skip_idle", 64'(out_valid), 64'd0);

        // 5: backpressure fills FIFO 2 (first word sits in the output register)
        do_reset();
        out_ready = 1'b0;
        in_valid  = 3'b100;
        for (int k = 0; k < 6; k++) expect_word(2, 32'h5000_0000 + 32'(k));
        for (int k = 0; k < 5; k++) begin
            set_word(2, 32'h5000_0000 + 32'(k));
            tick();
        end
        check("full_in_ready", 64'(in_ready),  64'b011);
        check("full_no_ovf",   64'(overflow),  64'd0);
        check("full_valid",    64'(out_valid), 64'd1);
        check("full_data",     64'(out_data),  64'h5000_0000);
        set_word(2, 32'h5000_0005);
        tick();
        check("full_overflow", 64'(overflow),  64'b100);
        check("full_refused",  64'(in_ready),  64'b011);
        tick();
        check("full_hold_data", 64'(out_data), 64'h5000_0000);
        check("full_hold_port", 64'(out_port), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !in_ready[2]; i++) tick();
        check("full_ready_back", 64'(in_ready[2]), 64'd1);
        tick();
        in_valid = '0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("full_drained", 64'(sb.size()), 64'd0);
        check("full_ovf_sticky", 64'(overflow), 64'b100);

        // 6: reset in the middle of operation
        do_reset();
        out_ready = 1'b0;
        in_valid  = 3'b100;
        for (int k = 0; k < 4; k++) begin
            set_word(2, 32'h6000_0000 + 32'(k));
            tick();
        end
        in_valid = '0;
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_in_ready",  64'(in_ready),  64'b111);
        check("mid_out_data",  64'(out_data),  64'd0);
        for (int p = 0; p < NPORTS; p++) begin
            set_word(p, 32'h7000_0000 | 32'(p));
            expect_word(p, 32'h7000_0000 | 32'(p));
        end
        in_valid  = 3'b111;
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        tick();
        check("mid_first_valid", 64'(out_valid), 64'd1);
        check("mid_first_port",  64'(out_port),  64'd0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("mid_stale_gone", 64'(out_valid), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
